accum_seq_ctrl: RTL

- Sequential controller that time-shares one WIDTH-bit adder over a burst of NOPS operands.
- Operands are collected through a valid/ready handshake, then accumulated one addition per cycle until the first carry-out.
- Reports the last non-overflowing running sum and the number of successful additions.
- Multi-cycle, single-adder replacement for the combinational four-input accumulate-until-overflow adder in the Lab5 datapath.

---
 rtl/accum_seq_ctrl_if.sv | 28 ++
 rtl/accum_seq_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/accum_seq_ctrl_if.sv
// Handshake and result bundle for accum_seq_ctrl.
// Master drives start/operands; slave is the controller.
interface accum_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
);
  logic             start;
  logic [WIDTH-1:0] op_in;
  logic             op_valid;
  logic             op_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output start, op_in, op_valid,
    input  op_ready, busy, done,
    input  sum, count, overflow
  );

  modport slave (
    input  start, op_in, op_valid,
    output op_ready, busy, done,
    output sum, count, overflow
  );
endinterface

// File: rtl/accum_seq_ctrl.sv
// Single-adder accumulate-until-carry controller over NOPS operands.
// Optional macro ACCUM_EARLY_EXIT_EN: leave ADD on the first carry-out.
module accum_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int NOPS  = 4,
  parameter int CNT_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  accum_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ADD,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NOPS - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t state, state_n;

  logic [WIDTH-1:0] slot [NOPS];
  logic [CNT_W-1:0] kidx;
  logic [CNT_W-1:0] step;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] good;
  logic             ovf;

  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic             ld;
  logic             fire;
  logic             last_ld;
  logic             last_st;
  logic [WIDTH:0]   add_w;
  logic             carry;
  logic [WIDTH-1:0] acc_n;
  logic [CNT_W-1:0] good_n;
  logic             ovf_n;
  logic             leave;

  assign ld      = (state == LOAD);
  assign fire    = ld && bus.op_valid;
  assign last_ld = (kidx == LAST);
  assign last_st = (step == LAST);

  assign add_w = {1'b0, acc} + {1'b0, slot[step]};
  assign carry = add_w[WIDTH];

  // Once a carry is seen the burst result is frozen.
  always_comb begin
    acc_n  = acc;
    good_n = good;
    ovf_n  = ovf;
    unique case (1'b1)
      ovf: begin
      end
      (!ovf && carry): begin
        ovf_n = 1'b1;
      end
      (!ovf && !carry): begin
        acc_n  = add_w[WIDTH-1:0];
        good_n = good + ONE;
      end
      default: begin
      end
    endcase
  end

`ifdef ACCUM_EARLY_EXIT_EN
  assign leave = last_st || (!ovf && carry);
`else
  assign leave = last_st;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.start) state_n = LOAD;
      LOAD: if (fire && last_ld) state_n = ADD;
      ADD:  if (leave) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NOPS; i++) slot[i] <= '0;
      kidx <= '0;
    end else if (fire) begin
      slot[kidx] <= bus.op_in;
      kidx       <= last_ld ? '0 : kidx + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      step <= '0;
      good <= '0;
      ovf  <= 1'b0;
    end else if (fire && last_ld) begin
      acc  <= slot[0];
      step <= ONE;
      good <= '0;
      ovf  <= 1'b0;
    end else if (state == ADD) begin
      acc  <= acc_n;
      good <= good_n;
      ovf  <= ovf_n;
      step <= step + ONE;
    end
  end

  // Publish on the edge into DONE so results are valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state == ADD && leave) begin
      sum_q   <= (good_n != '0) ? acc_n : '0;
      count_q <= good_n;
      ovf_q   <= ovf_n;
    end
  end

  assign bus.op_ready = ld;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.sum      = sum_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule
